// File: rtl/lfsr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_ctrl_pkg
// Shared definitions for the LFSR sharing controller and its arbiter.
//   LFSR_W            : width of the shared LFSR state / seed
//   DEFAULT_SEED_INIT : seed used after reset and whenever a seed would be zero
//   state_e           : controller FSM states
//   nonzero_seed()    : replaces an all-zero seed (LFSR lock-up value)
// ---------------------------------------------------------------------------
package lfsr_ctrl_pkg;

    localparam int LFSR_W = 7;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED_INIT = 7'h5A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEED    = 2'd1,
        RUN     = 2'd2,
        DELIVER = 2'd3
    } state_e;

    // An all-zero seed would park an XOR-feedback LFSR forever, so it is
    // swapped for the fallback seed.
    function automatic logic [LFSR_W-1:0] nonzero_seed(
        input logic [LFSR_W-1:0] val,
        input logic [LFSR_W-1:0] fallback
    );
        logic [LFSR_W-1:0] res;
        if (val == {LFSR_W{1'b0}}) begin
            res = fallback;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage : lfsr_ctrl_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The winner is the first asserted
// request at an index >= ptr_i, searching upward and wrapping modulo NUM_REQ.
//   req_i     [NUM_REQ] : request vector
//   ptr_i     [PTR_W]   : highest-priority index (must be < NUM_REQ)
//   gnt_o     [NUM_REQ] : one-hot grant (all zero when no request)
//   gnt_idx_o [PTR_W]   : binary index of the grant
//   gnt_vld_o           : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [PTR_W:0] NUM_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0] cand_s;

    // Scan from ptr_i upward with explicit wrap; first hit wins.
    always_comb begin
        gnt_o     = {NUM_REQ{1'b0}};
        gnt_idx_o = {PTR_W{1'b0}};
        gnt_vld_o = 1'b0;
        cand_s    = {(PTR_W+1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (cand_s >= NUM_W) begin
                cand_s = cand_s - NUM_W;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_vld_o && req_i[cand_s[PTR_W-1:0]]) begin
                gnt_vld_o                    = 1'b1;
                gnt_o[cand_s[PTR_W-1:0]]     = 1'b1;
                gnt_idx_o                    = cand_s[PTR_W-1:0];
            end else begin
                gnt_vld_o = gnt_vld_o;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/lfsr_share_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_share_ctrl
// Shares one 7-bit LFSR among NUM_REQ requesters. Per grant it reseeds the
// LFSR (SEED), runs it until lfsr_done_i or a watchdog expiry (RUN), then
// returns the captured value with a one-cycle ack (DELIVER). The delivered
// value becomes the next seed so consecutive grants never repeat a sequence.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req_i    [NUM_REQ]    : level requests, held until ack
//   ack_o    [NUM_REQ]    : one-hot, one-cycle delivery strobe
//   rand_o   [7]          : last delivered value, holds between deliveries
//   err_o                 : pulses with ack_o when delivery was forced by timeout
//   busy_o                : controller is not in IDLE
//   seed_load_i, seed_i   : overwrite the seed register (zero -> SEED_INIT)
//   lfsr_rst_o            : registered active-high LFSR reset / seed load
//   lfsr_en_o             : LFSR step enable (RUN only)
//   lfsr_seed_o [7]       : current seed register
//   lfsr_out_i  [7]       : LFSR state
//   lfsr_done_i           : LFSR completion flag (only observed in RUN)
// ---------------------------------------------------------------------------
module lfsr_share_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int                NUM_REQ   = 4,
    parameter logic [LFSR_W-1:0] SEED_INIT = DEFAULT_SEED_INIT,
    parameter int                TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_i,
    output logic [NUM_REQ-1:0]  ack_o,
    output logic [LFSR_W-1:0]   rand_o,
    output logic                err_o,
    output logic                busy_o,
    input  logic                seed_load_i,
    input  logic [LFSR_W-1:0]   seed_i,
    output logic                lfsr_rst_o,
    output logic                lfsr_en_o,
    output logic [LFSR_W-1:0]   lfsr_seed_o,
    input  logic [LFSR_W-1:0]   lfsr_out_i,
    input  logic                lfsr_done_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = {WD_W{1'b1}};

    // FSM
    state_e state_q;
    state_e state_d;

    // Arbiter interface
    logic [NUM_REQ-1:0] gnt_s;
    logic [PTR_W-1:0]   gnt_idx_s;
    logic               gnt_vld_s;

    // Datapath registers
    logic [PTR_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] winner_q;
    logic [PTR_W-1:0]   win_idx_q;
    logic [LFSR_W-1:0]  seed_q;
    logic [LFSR_W-1:0]  rand_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               err_q;
    logic [WD_W-1:0]    wd_q;
    logic               lfsr_rst_q;

    // Decoded controls
    logic               run_exit_s;
    logic               timeout_s;
    logic               lfsr_en_s;
    logic               busy_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // lfsr_done_i has priority over the watchdog in the same cycle, so a
    // late-but-successful completion is never flagged as an error.
    assign run_exit_s = (state_q == RUN) && (lfsr_done_i || (wd_q == WD_LAST));
    assign timeout_s  = (state_q == RUN) && !lfsr_done_i && (wd_q == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld_s) begin
                    state_d = SEED;
                end else begin
                    state_d = IDLE;
                end
            end
            SEED: begin
                state_d = RUN;
            end
            RUN: begin
                if (run_exit_s) begin
                    state_d = DELIVER;
                end else begin
                    state_d = RUN;
                end
            end
            DELIVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from the current state.
    always_comb begin
        lfsr_en_s = 1'b0;
        busy_s    = 1'b1;
        case (state_q)
            IDLE:    busy_s    = 1'b0;
            SEED:    lfsr_en_s = 1'b0;
            RUN:     lfsr_en_s = 1'b1;
            DELIVER: lfsr_en_s = 1'b0;
            default: begin
                lfsr_en_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Watchdog: cleared while seeding, counts RUN cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= {WD_W{1'b0}};
        end else if (state_q == SEED) begin
            wd_q <= {WD_W{1'b0}};
        end else if ((state_q == RUN) && (wd_q != WD_MAX)) begin
            wd_q <= wd_q + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_q <= wd_q;
        end
    end

    // Latch the arbitration winner when leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q  <= {NUM_REQ{1'b0}};
            win_idx_q <= {PTR_W{1'b0}};
        end else if ((state_q == IDLE) && gnt_vld_s) begin
            winner_q  <= gnt_s;
            win_idx_q <= gnt_idx_s;
        end else begin
            winner_q  <= winner_q;
            win_idx_q <= win_idx_q;
        end
    end

    // Capture the LFSR value at RUN exit and arm the one-cycle ack/err strobes
    // so they line up with the DELIVER state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rand_q <= {LFSR_W{1'b0}};
            ack_q  <= {NUM_REQ{1'b0}};
            err_q  <= 1'b0;
        end else if (run_exit_s) begin
            rand_q <= lfsr_out_i;
            ack_q  <= winner_q;
            err_q  <= timeout_s;
        end else begin
            rand_q <= rand_q;
            ack_q  <= {NUM_REQ{1'b0}};
            err_q  <= 1'b0;
        end
    end

    // Round-robin pointer moves past the requester just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {PTR_W{1'b0}};
        end else if (state_q == DELIVER) begin
            if (win_idx_q == PTR_LAST) begin
                ptr_q <= {PTR_W{1'b0}};
            end else begin
                ptr_q <= win_idx_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_q <= ptr_q;
        end
    end

    // Seed register: an explicit load beats the chained update in DELIVER.
    // The LFSR copies seed_q at the end of SEED, so a load in that same cycle
    // only affects later grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= SEED_INIT;
        end else if (seed_load_i) begin
            seed_q <= nonzero_seed(seed_i, SEED_INIT);
        end else if (state_q == DELIVER) begin
            seed_q <= nonzero_seed(rand_q, SEED_INIT);
        end else begin
            seed_q <= seed_q;
        end
    end

    // LFSR reset: held during reset, then asserted only for the SEED cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_rst_q <= 1'b1;
        end else begin
            lfsr_rst_q <= (state_d == SEED);
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rand_o      = rand_q;
    assign busy_o      = busy_s;
    assign lfsr_en_o   = lfsr_en_s;
    assign lfsr_rst_o  = lfsr_rst_q;
    assign lfsr_seed_o = seed_q;

endmodule : lfsr_share_ctrl

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
- Round-robin controller that shares the single 7-bit LFSR among NUM_REQ requesters.
- Per granted request it reseeds the LFSR, enables it until it signals completion, captures the value, and returns it with a one-cycle ack.
- Sits between game-logic requesters and the LFSR instance. It owns the LFSR's reset, enable and seed pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEED_INIT, 7'h5A, seed used after reset, and whenever the chained seed would be zero.
- TIMEOUT, 15, maximum RUN cycles without lfsr_done_i before a forced deliver.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  level request per requester; held until the matching ack.
- ack_o  out  NUM_REQ  one-hot, one-cycle pulse; rand_o is valid in the same cycle.
- rand_o  out  7  registered delivered value; holds until the next delivery.
- err_o  out  1  one-cycle pulse with ack_o when the delivery was forced by timeout.
- busy_o  out  1  high in every state except IDLE.
- seed_load_i  in  1  write seed_i into the seed register.
- seed_i  in  7  configuration seed.
- lfsr_rst_o  out  1  registered, active-high reset to the LFSR.
- lfsr_en_o  out  1  LFSR enable.
- lfsr_seed_o  out  7  equals seed register seed_q.
- lfsr_out_i  in  7  LFSR state.
- lfsr_done_i  in  1  LFSR completion flag.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, ptr=0, seed_q=SEED_INIT.
  - rand_o=0, ack_o=0, err_o=0, busy_o=0, lfsr_en_o=0.
  - lfsr_rst_o=1, so the LFSR is held in reset; it falls to 0 on the first clock edge after release.
- Reset mid-transaction: abort with no ack; the pending requester is re-arbitrated afterwards.
- FSM IDLE -> SEED -> RUN -> DELIVER -> IDLE. All outputs are registered or decoded from state only.
- IDLE:
  - If any req_i is high, latch the one-hot winner and go to SEED.
  - Winner is the first asserted request at index >= ptr, wrapping modulo NUM_REQ.
- SEED (1 cycle):
  - lfsr_rst_o=1, lfsr_seed_o=seed_q. The LFSR loads the seed and clears its completion flag.
- RUN:
  - lfsr_en_o=1; watchdog wd counts from 0.
  - If lfsr_done_i=1: capture lfsr_out_i into rand_q and go to DELIVER.
  - Else if wd==TIMEOUT-1: capture lfsr_out_i, set err flag, go to DELIVER.
  - lfsr_done_i is ignored outside RUN.
- DELIVER (1 cycle):
  - ack_o[winner]=1, rand_o=rand_q, err_o=err flag.
  - ptr <= (winner+1) mod NUM_REQ.
  - seed_q <= rand_q, or SEED_INIT if rand_q==0 (chaining avoids repeated sequences).
  - Return to IDLE. Arbitration happens in IDLE, so there is one idle cycle between back-to-back grants.
- Latency with a compliant LFSR (7 enabled steps, done registered):
  - req sampled in IDLE at cycle 0; SEED at 1; RUN 2..9; ack at cycle 10.
- Requester protocol:
  - req must stay high until ack.
  - Dropping req before ack does not cancel the transaction; the ack is still issued.
  - req still high in the cycle after ack counts as a new request.
- seed_load_i:
  - Accepted in any state; takes effect at the next SEED.
  - A load in the SEED cycle does not affect the current transaction.
  - Simultaneous with the DELIVER seed update: seed_load_i wins.
  - seed_i==0 is replaced by SEED_INIT.
- Arithmetic:
  - ptr width is clog2(NUM_REQ), with explicit wrap.
  - wd width is clog2(TIMEOUT+1) and saturates.

Decomposition:
- Package lfsr_ctrl_pkg:
  - LFSR_W=7.
  - state enum {IDLE, SEED, RUN, DELIVER}.
  - default SEED_INIT.
- Sub-module rr_arbiter:
  - Combinational: req vector + ptr -> one-hot grant + grant index.
  - Reusable by other shared resources.

Test Plan:
- Single request: reset, req_i=4'b0010 at cycle 0 with a real LFSR and SEED_INIT=7'h5A -> ack_o=4'b0010 at cycle 10, rand_o equal to the seed stepped 7 times, err_o=0, busy_o high for cycles 1-10.
- Round robin: req_i=4'b1111 held continuously -> acks issued in order 0,1,2,3,0, each separated by 11 cycles.
- Seed chaining: two back-to-back grants to requester 0 -> second lfsr_seed_o during SEED equals the first rand_o. Forcing a captured value of 0 -> next seed is 7'h5A.
- Timeout: stub LFSR with lfsr_done_i tied 0 -> ack and err_o pulse after exactly 15 RUN cycles (cycle 17), rand_o=lfsr_out_i sampled in the last RUN cycle.
- seed_load_i with seed_i=7'h11 during RUN, concurrent with its DELIVER -> next SEED drives 7'h11. seed_i=0 -> next SEED drives 7'h5A.
- Reset mid-RUN: rst_n low at cycle 5 -> no ack, lfsr_rst_o=1, rand_o=0. After release, a held req is re-granted from ptr=0.
